// File: rtl/stopwatch_core.sv
// stopwatch_core: run/stop/clear stopwatch producing centisecond, second, minute and hour counts.
// Optional build macro LAP_HOLD_EN adds i_lap, which freezes the time outputs on a lap snapshot.
module stopwatch_core #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned TICK_HZ     = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_run_stop,
   input  logic       i_clear,
`ifdef LAP_HOLD_EN
   input  logic       i_lap,
`endif
   output logic [6:0] o_msec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_running
);

   localparam int unsigned DIV_CNT        = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned DIV_W          = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
   localparam logic [DIV_W-1:0] DIV_TERM  = DIV_W'(DIV_CNT - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_running;
   logic [DIV_W-1:0] r_div;
   logic [6:0]       r_msec;
   logic [5:0]       r_sec;
   logic [5:0]       r_min;
   logic [4:0]       r_hour;

   logic             w_tick;
   logic [6:0]       w_nxt_msec;
   logic [5:0]       w_nxt_sec;
   logic [5:0]       w_nxt_min;
   logic [4:0]       w_nxt_hour;

   // Control FSM; o_running is registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_STOP;
         r_running <= 1'b0;
      end else begin
         case (r_state)
            ST_STOP: begin
               if (i_clear) begin
                  r_state   <= ST_CLEAR;
                  r_running <= 1'b0;
               end else if (i_run_stop) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_run_stop) begin
                  r_state   <= ST_STOP;
                  r_running <= 1'b0;
               end
            end
            ST_CLEAR: begin
               r_state   <= ST_STOP;
               r_running <= 1'b0;
            end
            default: begin
               r_state   <= ST_STOP;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   // Tick decision uses the current state, so a stop pulse on the terminal count still ticks.
   assign w_tick = (r_state == ST_RUN) && (r_div == DIV_TERM);

   // Divider holds its fraction while stopped so a resume continues mid-tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_div <= '0;
      end else if (r_state == ST_RUN) begin
         if (r_div >= DIV_TERM) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // Cascaded carries; a full 23:59:59.99 rollover resolves in one edge.
   always_comb begin
      w_nxt_msec = r_msec;
      w_nxt_sec  = r_sec;
      w_nxt_min  = r_min;
      w_nxt_hour = r_hour;
      if (w_tick) begin
         if (r_msec >= 7'd99) begin
            w_nxt_msec = 7'd0;
            if (r_sec >= 6'd59) begin
               w_nxt_sec = 6'd0;
               if (r_min >= 6'd59) begin
                  w_nxt_min = 6'd0;
                  if (r_hour >= 5'd23) begin
                     w_nxt_hour = 5'd0;
                  end else begin
                     w_nxt_hour = r_hour + 5'd1;
                  end
               end else begin
                  w_nxt_min = r_min + 6'd1;
               end
            end else begin
               w_nxt_sec = r_sec + 6'd1;
            end
         end else begin
            w_nxt_msec = r_msec + 7'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msec <= 7'd0;
         r_sec  <= 6'd0;
         r_min  <= 6'd0;
         r_hour <= 5'd0;
      end else if (r_state == ST_CLEAR) begin
         r_msec <= 7'd0;
         r_sec  <= 6'd0;
         r_min  <= 6'd0;
         r_hour <= 5'd0;
      end else begin
         r_msec <= w_nxt_msec;
         r_sec  <= w_nxt_sec;
         r_min  <= w_nxt_min;
         r_hour <= w_nxt_hour;
      end
   end

   assign o_running = r_running;

`ifdef LAP_HOLD_EN
   logic       r_lap;
   logic       w_lap_nxt;
   logic [6:0] r_disp_msec;
   logic [5:0] r_disp_sec;
   logic [5:0] r_disp_min;
   logic [4:0] r_disp_hour;

   always_comb begin
      w_lap_nxt = r_lap;
      if (r_state == ST_CLEAR) begin
         w_lap_nxt = 1'b0;
      end else if ((r_state == ST_RUN) && i_lap) begin
         w_lap_nxt = ~r_lap;
      end
   end

   // Display registers track the live count and simply stop loading while the lap flag is set,
   // which leaves them holding the value shown on the setting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lap       <= 1'b0;
         r_disp_msec <= 7'd0;
         r_disp_sec  <= 6'd0;
         r_disp_min  <= 6'd0;
         r_disp_hour <= 5'd0;
      end else begin
         r_lap <= w_lap_nxt;
         if (r_state == ST_CLEAR) begin
            r_disp_msec <= 7'd0;
            r_disp_sec  <= 6'd0;
            r_disp_min  <= 6'd0;
            r_disp_hour <= 5'd0;
         end else if (!w_lap_nxt) begin
            r_disp_msec <= w_nxt_msec;
            r_disp_sec  <= w_nxt_sec;
            r_disp_min  <= w_nxt_min;
            r_disp_hour <= w_nxt_hour;
         end
      end
   end

   assign o_msec = r_disp_msec;
   assign o_sec  = r_disp_sec;
   assign o_min  = r_disp_min;
   assign o_hour = r_disp_hour;
`else
   assign o_msec = r_msec;
   assign o_sec  = r_sec;
   assign o_min  = r_min;
   assign o_hour = r_hour;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a time-in-centiseconds reference model feeds an expected
// queue that a cycle monitor drains and compares against the DUT outputs.
module tb_stopwatch_core;

   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned TICK   = 100;
   localparam int          DIV    = CLK_HZ / TICK;
   localparam int          DAY    = 24 * 60 * 60 * 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run_stop = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       running;

`ifdef LAP_HOLD_EN
   logic lap = 1'b0;
   bit   lap_pend = 1'b0;
   bit   m_lap = 1'b0;
   int   m_snap = 0;
`endif

   int   m_tot = 0;
   int   m_frac = 0;
   bit   m_run = 1'b0;
   bit   m_clr = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;

   logic [24:0] exp_q[$];

   stopwatch_core #(
      .CLK_FREQ_HZ(CLK_HZ),
      .TICK_HZ    (TICK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_run_stop(run_stop),
      .i_clear   (clear),
`ifdef LAP_HOLD_EN
      .i_lap     (lap),
`endif
      .o_msec    (msec),
      .o_sec     (sec),
      .o_min     (min),
      .o_hour    (hour),
      .o_running (running)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] pack(input int tot, input bit run);
      return {run, 5'((tot / 360000) % 24), 6'((tot / 6000) % 60),
              6'((tot / 100) % 60), 7'(tot % 100)};
   endfunction

   function automatic logic [24:0] expected();
`ifdef LAP_HOLD_EN
      return pack(m_lap ? m_snap : m_tot, m_run);
`else
      return pack(m_tot, m_run);
`endif
   endfunction

   task automatic compare(input logic [24:0] exp, input string name);
      logic [24:0] act;
      act = {running, hour, min, sec, msec};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got run=%0d %0d:%0d:%0d.%0d want run=%0d %0d:%0d:%0d.%0d",
                  name, $time, act[24], act[23:19], act[18:13], act[12:7], act[6:0],
                  exp[24], exp[23:19], exp[18:13], exp[12:7], exp[6:0]);
      end
   endtask

   task automatic model_reset();
      m_tot = 0; m_frac = 0; m_run = 1'b0; m_clr = 1'b0;
`ifdef LAP_HOLD_EN
      m_lap = 1'b0; m_snap = 0;
`endif
   endtask

   // One clock edge of the reference: time advances by whole ticks of DIV clocks while running.
   task automatic model_edge(input bit rs, input bit clr);
      if (m_clr) begin
         model_reset();
      end else if (m_run) begin
`ifdef LAP_HOLD_EN
         if (lap) begin
            if (!m_lap) m_snap = m_tot;
            m_lap = !m_lap;
         end
`endif
         m_frac++;
         if (m_frac == DIV) begin
            m_frac = 0;
            m_tot  = (m_tot + 1) % DAY;
         end
         if (rs) m_run = 1'b0;
      end else begin
         if (clr)     m_clr = 1'b1;
         else if (rs) m_run = 1'b1;
      end
   endtask

   task automatic step(input bit rs, input bit clr);
      @(negedge clk);
      run_stop = rs;
      clear    = clr;
`ifdef LAP_HOLD_EN
      lap      = lap_pend;
      lap_pend = 1'b0;
`endif
      model_edge(rs, clr);
      exp_q.push_back(expected());
      @(posedge clk);
      #2;
      run_stop = 1'b0;
      clear    = 1'b0;
`ifdef LAP_HOLD_EN
      lap      = 1'b0;
`endif
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare(pack(0, 1'b0), "async_rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every edge with an outstanding expectation is checked just after the edge.
   initial begin
      logic [24:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            compare(exp, "cycle");
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      compare(pack(0, 1'b0), "por");
      @(negedge clk);
      rst = 1'b0;

      repeat (50) step(1'b0, 1'b0);

      // Long run across the first second boundary.
      step(1'b1, 1'b0);
      repeat (1010) step(1'b0, 1'b0);

      // Stop, then clear and run_stop together (clear wins).
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0);

      // Pause mid-tick and resume: fraction must carry over.
      step(1'b1, 1'b0);
      repeat (24) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);

      // Clear while running is ignored.
      step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);

      async_reset();
      repeat (50) step(1'b0, 1'b0);

`ifdef LAP_HOLD_EN
      step(1'b1, 1'b0);
      for (int i = 0; i < 200 && m_tot != 7; i++) step(1'b0, 1'b0);
      lap_pend = 1'b1;
      step(1'b0, 1'b0);
      for (int i = 0; i < 500 && m_tot != 40; i++) step(1'b0, 1'b0);
      lap_pend = 1'b1;
      step(1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b0);
`endif

      // Random pulse mix.
      for (int i = 0; i < 2000; i++) begin
`ifdef LAP_HOLD_EN
         lap_pend = ($urandom_range(0, 49) == 0);
`endif
         step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      end

      // Preload 23:59:59.99 from a cleared, stopped state and let one tick roll everything over.
      if (m_run) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      @(negedge clk);
      force dut.r_msec = 7'd99;
      force dut.r_sec  = 6'd59;
      force dut.r_min  = 6'd59;
      force dut.r_hour = 5'd23;
      m_tot = DAY - 1;
      exp_q.push_back(expected());
      @(posedge clk);
      #2;
      release dut.r_msec;
      release dut.r_sec;
      release dut.r_min;
      release dut.r_hour;
      step(1'b1, 1'b0);
      repeat (15) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Upstream time source for the 4-digit FND display controller. Produces the msec (centiseconds), sec, min and hour values that the controller splits into digits.
- Run/stop/clear control FSM driven by single-cycle button pulses (debounced and edge-detected upstream).
- Internal tick divider plus cascaded BCD-range binary counters.
- Outputs are registered and connect directly to the display controller's time inputs.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
TICK_HZ, 100, count rate of o_msec (100 = 10 ms resolution). Divider terminal value is CLK_FREQ_HZ/TICK_HZ-1; CLK_FREQ_HZ must be an integer multiple of TICK_HZ.

Ports:
clk  in  1  system clock; all logic on posedge clk.
rst  in  1  reset, asynchronous, active-high.
i_run_stop  in  1  one-cycle pulse; toggles between run and stop.
i_clear  in  1  one-cycle pulse; zeroes the time, honoured only when stopped.
o_msec  out  7  centiseconds, range 0..99.
o_sec  out  6  seconds, range 0..59.
o_min  out  6  minutes, range 0..59.
o_hour  out  5  hours, range 0..23.
o_running  out  1  high while the FSM is in RUN.

Behaviour:
- Reset is async on rst. All outputs go to 0, the FSM goes to STOP and the divider goes to 0.
- FSM states are STOP, RUN and CLEAR. State is registered; o_running = (state==RUN).
- STOP:
  - i_clear -> CLEAR. i_clear has priority if asserted in the same cycle as i_run_stop.
  - Otherwise i_run_stop -> RUN.
- RUN:
  - i_run_stop -> STOP.
  - i_clear is ignored and has no effect.
- CLEAR: lasts exactly one cycle, then unconditionally -> STOP. Any pulses arriving during CLEAR are ignored. On the edge leaving CLEAR, all counters and the divider are zeroed.
- Divider:
  - Increments only in RUN. It holds its value in STOP, so the sub-tick fraction is preserved across pause/resume, and is zeroed by CLEAR.
  - When it reaches the terminal value in RUN, it wraps to 0 and asserts an internal one-cycle tick.
- Counter cascade:
  - Counters update on the same edge the divider wraps, so the new value is visible the cycle after the terminal count.
  - o_msec 99->0 carries into o_sec; o_sec 59->0 carries into o_min; o_min 59->0 carries into o_hour; o_hour 23->0 with no further carry.
  - A full rollover from 23:59:59.99 to 00:00:00.00 occurs in a single edge.
- Counters never exceed their range. Widths are fixed at 7/6/6/5 bits to match the display controller inputs.
- Stop latency: an i_run_stop pulse in RUN moves the FSM to STOP on that edge. If the divider is at terminal on that same edge, the tick still occurs, because the decision uses the current state (RUN).
- Start latency: counting starts the cycle after the FSM enters RUN.
- Reset mid-run: outputs go to 0 immediately (asynchronous). After release the block waits in STOP.

Optional Feature:
Macro LAP_HOLD_EN.
- Defined:
  - Adds input port i_lap (1 bit, one-cycle pulse) and a lap-hold flag, reset to 0.
  - In RUN, i_lap toggles the flag. While the flag is set, the o_* time outputs hold the snapshot captured on the setting edge; internal counting continues.
  - Clearing the flag returns the outputs to the live counters on the next cycle.
  - Entering STOP keeps the flag. CLEAR and rst clear the flag.
  - i_lap is ignored outside RUN.
- Undefined: no i_lap port and no flag. Outputs always show the live counters.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, TICK_HZ=100, i.e. 10 clocks per tick.
1. rst pulse mid-operation -> all outputs 0 and o_running=0 asynchronously; after 50 clocks with no pulses, outputs remain 0.
2. i_run_stop, then 1000 clocks -> o_msec=99 and o_sec=0; 10 more clocks -> o_msec=0 and o_sec=1; o_running=1 throughout.
3. Run, then i_run_stop after 25 clocks -> o_msec=2 frozen. Resume -> the next increment comes 5 clocks later (fraction preserved).
4. While stopped, assert i_clear and i_run_stop in the same cycle -> CLEAR for one cycle, then STOP, outputs 0, o_running stays 0. i_clear in RUN -> no change.
5. Force counters to 23:59:59.99 via a backdoor preload, then run 10 clocks -> all outputs become 0 on the same edge.
6. With LAP_HOLD_EN: in RUN at o_msec=7, pulse i_lap -> outputs hold 7 while the internal count advances; pulse again at internal 40 -> o_msec=40 the next cycle.
